// File: rtl/cpu_run_controller_if.sv
// Host-side load channel of the run controller: one word per accept,
// steered to instruction or data memory by ld_sel.
interface cpu_run_controller_if;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_sel;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    modport master (
        output ld_valid,
        output ld_sel,
        output ld_addr,
        output ld_data,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_sel,
        input  ld_addr,
        input  ld_data,
        output ld_ready
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Run supervisor for the single-cycle CPU: loads memories while the CPU is held
// in reset, runs it, and reports why the run stopped (halt, overflow, timeout).
module cpu_run_controller #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       clear,
    input  logic [31:0]                halt_pc,
    cpu_run_controller_if.slave        ld,
    output logic                       im_we,
    output logic                       dm_we,
    output logic [29:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic                       cpu_rst,
    input  logic [31:0]                cpu_pc,
    input  logic                       cpu_overflow,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 status,
    output logic                       ovf_at_halt,
    output logic                       load_err,
    output logic [31:0]                cycles
);

    typedef enum logic [1:0] {
        StLoad,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] StatusNone     = 2'b00;
    localparam logic [1:0] StatusHalted   = 2'b01;
    localparam logic [1:0] StatusOverflow = 2'b10;
    localparam logic [1:0] StatusTimeout  = 2'b11;

    localparam logic [31:0] LastCycle = TIMEOUT - 1;

    state_e      state_q, state_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        ld_ready_q, ld_ready_d;
    logic        im_we_q, im_we_d;
    logic        dm_we_q, dm_we_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  status_q, status_d;
    logic        ovf_at_halt_q, ovf_at_halt_d;
    logic        load_err_q, load_err_d;
    logic [31:0] cycles_q, cycles_d;
    logic        accept;

    assign accept = ld.ld_valid & ld_ready_q;

    always_comb begin
        state_d       = state_q;
        im_we_d       = 1'b0;
        dm_we_d       = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        status_d      = status_q;
        ovf_at_halt_d = ovf_at_halt_q;
        load_err_d    = load_err_q;
        cycles_d      = cycles_q;

        case (state_q)
            StLoad: begin
                if (accept) begin
                    if (ld.ld_addr[1:0] == 2'b00) begin
                        im_we_d     = ~ld.ld_sel;
                        dm_we_d     = ld.ld_sel;
                        mem_addr_d  = ld.ld_addr[31:2];
                        mem_wdata_d = ld.ld_data;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
                // A start coinciding with an offered word is dropped, not deferred.
                if (start && !ld.ld_valid) begin
                    state_d       = StRun;
                    cycles_d      = '0;
                    status_d      = StatusNone;
                    ovf_at_halt_d = 1'b0;
                end
            end

            StRun: begin
                if (cpu_pc == halt_pc) begin
                    state_d       = StDone;
                    status_d      = StatusHalted;
                    ovf_at_halt_d = cpu_overflow;
                end else if (cpu_overflow) begin
                    state_d  = StDone;
                    status_d = StatusOverflow;
                    cycles_d = cycles_q + 32'd1;
                end else if (cycles_q == LastCycle) begin
                    state_d  = StDone;
                    status_d = StatusTimeout;
                    cycles_d = cycles_q + 32'd1;
                end else begin
                    cycles_d = cycles_q + 32'd1;
                end
            end

            StDone: begin
                if (clear) begin
                    state_d       = StLoad;
                    status_d      = StatusNone;
                    cycles_d      = '0;
                    ovf_at_halt_d = 1'b0;
                end
            end

            default: begin
                state_d = StLoad;
            end
        endcase

        // Registered copies of decoded next state keep these outputs glitch-free.
        ld_ready_d = (state_d == StLoad);
        cpu_rst_d  = (state_d != StRun);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StLoad;
            cpu_rst_q     <= 1'b1;
            ld_ready_q    <= 1'b0;
            im_we_q       <= 1'b0;
            dm_we_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            status_q      <= StatusNone;
            ovf_at_halt_q <= 1'b0;
            load_err_q    <= 1'b0;
            cycles_q      <= '0;
        end else begin
            state_q       <= state_d;
            cpu_rst_q     <= cpu_rst_d;
            ld_ready_q    <= ld_ready_d;
            im_we_q       <= im_we_d;
            dm_we_q       <= dm_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            status_q      <= status_d;
            ovf_at_halt_q <= ovf_at_halt_d;
            load_err_q    <= load_err_d;
            cycles_q      <= cycles_d;
        end
    end

    assign ld.ld_ready   = ld_ready_q;
    assign im_we         = im_we_q;
    assign dm_we         = dm_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_rst       = cpu_rst_q;
    assign status        = status_q;
    assign ovf_at_halt   = ovf_at_halt_q;
    assign load_err      = load_err_q;
    assign cycles        = cycles_q;
    assign busy          = (state_q == StRun);
    assign done          = (state_q == StDone);

endmodule
